// File: rtl/rr_prio_enc.sv
// N-input priority encoder with registered index/one-hot outputs and a
// valid/ready output handshake; fixed-priority or round-robin selection.
module rr_prio_enc #(
  parameter int unsigned N  = 8,
  parameter int unsigned W  = 3,
  parameter int unsigned RR = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot,
  output logic         out_multi
);

  localparam int unsigned CW = W + 1;

  logic         valid_q, valid_d;
  logic [W-1:0] idx_q, idx_d;
  logic [N-1:0] onehot_q, onehot_d;
  logic         multi_q, multi_d;
  logic [W-1:0] ptr_q, ptr_d;

  logic [W-1:0]  start_c;
  logic [W-1:0]  sel_c;
  logic          found_c;
  logic [CW-1:0] cand_c;
  logic          multi_c;
  logic          load_c;
  logic          capture_c;

  // Scan upward from the start position, wrapping at N without assuming a power of two.
  always_comb begin
    start_c = (RR != 0) ? ptr_q : '0;
    sel_c   = '0;
    found_c = 1'b0;
    cand_c  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand_c = {1'b0, start_c} + CW'(i);
      if (cand_c >= CW'(N)) begin
        cand_c = cand_c - CW'(N);
      end
      if (!found_c && req[W'(cand_c)]) begin
        found_c = 1'b1;
        sel_c   = W'(cand_c);
      end
    end
  end

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_c = |(req & (req - N'(1)));

  assign load_c    = !valid_q || out_ready;
  assign capture_c = load_c && en && (req != '0);

  always_comb begin
    valid_d  = valid_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    multi_d  = multi_q;
    ptr_d    = ptr_q;
    if (load_c) begin
      valid_d = capture_c;
      if (capture_c) begin
        idx_d    = sel_c;
        onehot_d = N'(1) << sel_c;
        multi_d  = multi_c;
        if (RR != 0) begin
          ptr_d = (sel_c == W'(N - 1)) ? '0 : sel_c + W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      idx_q    <= '0;
      onehot_q <= '0;
      multi_q  <= 1'b0;
      ptr_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
      multi_q  <= multi_d;
      ptr_q    <= ptr_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_idx    = idx_q;
  assign out_onehot = onehot_q;
  assign out_multi  = multi_q;

endmodule

// File: tb/tb_rr_prio_enc.sv
// Bench for rr_prio_enc: three configurations (N=8 RR, N=8 fixed, N=5 RR)
// checked every cycle against a behavioural model, plus directed expectations.
module tb_rr_prio_enc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       out_ready = 1'b1;
  logic [7:0] req_a = 8'hFF;
  logic [7:0] req_b = 8'b0010_1100;
  logic [4:0] req_c = 5'b10001;

  logic       a_valid, b_valid, c_valid;
  logic [2:0] a_idx, b_idx, c_idx;
  logic [7:0] a_oh, b_oh;
  logic [4:0] c_oh;
  logic       a_multi, b_multi, c_multi;

  rr_prio_enc #(.N(8), .W(3), .RR(1)) u_a (
    .clk(clk), .rst(rst), .en(en), .req(req_a), .out_ready(out_ready),
    .out_valid(a_valid), .out_idx(a_idx), .out_onehot(a_oh), .out_multi(a_multi));

  rr_prio_enc #(.N(8), .W(3), .RR(0)) u_b (
    .clk(clk), .rst(rst), .en(en), .req(req_b), .out_ready(out_ready),
    .out_valid(b_valid), .out_idx(b_idx), .out_onehot(b_oh), .out_multi(b_multi));

  rr_prio_enc #(.N(5), .W(3), .RR(1)) u_c (
    .clk(clk), .rst(rst), .en(en), .req(req_c), .out_ready(out_ready),
    .out_valid(c_valid), .out_idx(c_idx), .out_onehot(c_oh), .out_multi(c_multi));

  int n_pass = 0;
  int n_total = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s got=%0d expected=%0d at t=%0t", name, act, exp, $time);
  endtask

  // Behavioural model: one entry per instance (0=a, 1=b, 2=c).
  int nn  [3] = '{8, 8, 5};
  int rrm [3] = '{1, 0, 1};
  int m_valid [3] = '{0, 0, 0};
  int m_idx   [3] = '{0, 0, 0};
  int m_oh    [3] = '{0, 0, 0};
  int m_multi [3] = '{0, 0, 0};
  int m_ptr   [3] = '{0, 0, 0};

  function automatic int req_of(input int d);
    if (d == 0) return int'(req_a);
    if (d == 1) return int'(req_b);
    return int'(req_c);
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      int r;
      int sel;
      int start;
      r = req_of(d);
      if (rst) begin
        m_valid[d] <= 0; m_idx[d] <= 0; m_oh[d] <= 0; m_multi[d] <= 0; m_ptr[d] <= 0;
      end else if (m_valid[d] == 0 || out_ready) begin
        if (en && r != 0) begin
          start = (rrm[d] != 0) ? m_ptr[d] : 0;
          sel = -1;
          for (int k = 0; k < nn[d]; k++) begin
            if (sel < 0 && r[(start + k) % nn[d]]) sel = (start + k) % nn[d];
          end
          m_valid[d] <= 1;
          m_idx[d]   <= sel;
          m_oh[d]    <= 1 << sel;
          m_multi[d] <= ($countones(r) > 1) ? 1 : 0;
          if (rrm[d] != 0) m_ptr[d] <= (sel + 1) % nn[d];
        end else begin
          m_valid[d] <= 0;
        end
      end
    end
  end

  // Compare every instance against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("a_valid", int'(a_valid), m_valid[0]);
      chk("a_idx", int'(a_idx), m_idx[0]);
      chk("a_onehot", int'(a_oh), m_oh[0]);
      chk("a_multi", int'(a_multi), m_multi[0]);
      chk("a_ptr", int'(u_a.ptr_q), m_ptr[0]);
      chk("b_valid", int'(b_valid), m_valid[1]);
      chk("b_idx", int'(b_idx), m_idx[1]);
      chk("b_onehot", int'(b_oh), m_oh[1]);
      chk("b_multi", int'(b_multi), m_multi[1]);
      chk("c_valid", int'(c_valid), m_valid[2]);
      chk("c_idx", int'(c_idx), m_idx[2]);
      chk("c_onehot", int'(c_oh), m_oh[2]);
      chk("c_multi", int'(c_multi), m_multi[2]);
      chk("c_ptr", int'(u_c.ptr_q), m_ptr[2]);
      chk("c_ptr_range", int'(u_c.ptr_q < 3'd5), 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick();
    tick();
    chk_on = 1'b1;
    chk("rst_valid", int'(a_valid), 0);
    chk("rst_idx", int'(a_idx), 0);
    chk("rst_onehot", int'(a_oh), 0);

    rst = 1'b0;
    for (int i = 0; i <= 8; i++) begin
      tick();
      chk("rr_seq_idx", int'(a_idx), i % 8);
      chk("rr_seq_valid", int'(a_valid), 1);
      chk("fp_idx", int'(b_idx), 2);
      chk("fp_onehot", int'(b_oh), 8'h04);
      chk("fp_multi", int'(b_multi), 1);
      chk("n5_idx", int'(c_idx), (i % 2 != 0) ? 4 : 0);
      if (i == 0) chk("first_multi", int'(a_multi), 1);
    end

    req_b = 8'h80;
    tick();
    chk("fp_top_idx", int'(b_idx), 7);
    chk("fp_top_multi", int'(b_multi), 0);

    req_a = 8'h08;
    tick();
    chk("stall_cap_idx", int'(a_idx), 3);
    out_ready = 1'b0;
    req_a = 8'h01;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_hold_idx", int'(a_idx), 3);
      chk("stall_hold_valid", int'(a_valid), 1);
    end
    out_ready = 1'b1;
    tick();
    chk("stall_release_idx", int'(a_idx), 0);

    en = 1'b0;
    req_a = 8'hFF;
    tick();
    chk("en0_valid", int'(a_valid), 0);
    chk("en0_idx_hold", int'(a_idx), 0);
    en = 1'b1;
    req_a = 8'h00;
    tick();
    chk("idle_valid", int'(a_valid), 0);
    chk("idle_ptr", int'(u_a.ptr_q), 1);
    req_a = 8'hFF;
    tick();
    chk("after_idle_idx", int'(a_idx), 1);
    out_ready = 1'b0;
    tick();
    chk("pre_rst_valid", int'(a_valid), 1);
    rst = 1'b1;
    tick();
    chk("rst_in_stall_valid", int'(a_valid), 0);
    rst = 1'b0;
    out_ready = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      req_a     = 8'($urandom);
      req_b     = 8'($urandom);
      req_c     = 5'($urandom);
      if ($urandom_range(0, 3) == 0) req_a = 8'h00;
      en        = ($urandom_range(0, 9) < 8);
      out_ready = ($urandom_range(0, 9) < 7);
      rst       = ($urandom_range(0, 199) == 0);
      tick();
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
